// File: rtl/fx3_pkg.sv
// Shared definitions for the FX3 slave-FIFO responder.
// Socket addresses, data width and the {last, data} word of the write path.
package fx3_pkg;

    localparam int FX3_DW = 32;
    localparam int FX3_WORD_W = FX3_DW + 1;

    localparam logic [1:0] FX3_ADDR_WR = 2'b00;
    localparam logic [1:0] FX3_ADDR_RD = 2'b01;

    typedef struct packed {
        logic              last;
        logic [FX3_DW-1:0] data;
    } fx3_word_t;

endpackage

// File: rtl/fx3_resp_fifo.sv
// Synchronous first-word-fall-through FIFO for one FX3 socket buffer.
// Ports: push/din in, pop/dout out (head word), full, empty, used_nxt.
// used_nxt is the occupancy the FIFO will hold after this clock edge.
// A pop is ignored when empty; a push while full lands only with a pop.
module fx3_resp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     used_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  wr_ptr_nxt;
    logic [AW:0]  rd_ptr_nxt;
    logic         do_push;
    logic         do_pop;

    // Wrap bit differs and index matches: the writer lapped the reader.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
    assign used_nxt   = wr_ptr_nxt - rd_ptr_nxt;

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

endmodule

// File: rtl/fx3_slave_fifo_responder.sv
// Device-side model of the FX3 synchronous slave FIFO, bridged to AXIS.
// Ports: clk/rst_n; FX3 pins (usb_addr, usb_din/usb_dout/usb_dout_oe,
// slcs_n, slwr_n, slrd_n, sloe_n, pktend_n, flaga..flagd); m_axis carries
// master-written words to the host, s_axis carries host words to be read;
// zlp_count, sticky overflow/underflow status.
module fx3_slave_fifo_responder
    import fx3_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int WATERMARK  = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        usb_addr,
    input  logic [FX3_DW-1:0] usb_din,
    output logic [FX3_DW-1:0] usb_dout,
    output logic              usb_dout_oe,
    input  logic              slcs_n,
    input  logic              slwr_n,
    input  logic              slrd_n,
    input  logic              sloe_n,
    input  logic              pktend_n,
    output logic              flaga,
    output logic              flagb,
    output logic              flagc,
    output logic              flagd,
    output logic [FX3_DW-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic [FX3_DW-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [15:0]       zlp_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int UW = AW + 1;

    logic                  wr_sel;
    logic                  rd_sel;
    logic                  wr_req;
    logic                  zlp_req;
    logic                  rd_req;
    logic                  rd_pop_ok;

    logic                  wr_full;
    logic                  wr_empty;
    logic [UW-1:0]         wr_used_nxt;
    logic [FX3_WORD_W-1:0] wr_head;
    fx3_word_t             wr_word;
    fx3_word_t             wr_in;

    logic                  rd_full;
    logic                  rd_empty;
    logic [UW-1:0]         rd_used_nxt;
    logic [FX3_DW-1:0]     rd_head;

    logic                  ready_en;

    logic [RD_LATENCY-1:0] pipe_v;
    logic [FX3_DW-1:0]     pipe_d [RD_LATENCY];

    assign wr_sel  = !slcs_n && (usb_addr == FX3_ADDR_WR);
    assign rd_sel  = !slcs_n && (usb_addr == FX3_ADDR_RD);
    assign wr_req  = wr_sel && !slwr_n;
    assign zlp_req = wr_sel && !pktend_n && slwr_n;
    assign rd_req  = rd_sel && !slrd_n;

    assign rd_pop_ok = rd_req && !rd_empty;

    assign wr_in.last = !pktend_n;
    assign wr_in.data = usb_din;

    fx3_resp_fifo #(
        .W     (FX3_WORD_W),
        .DEPTH (DEPTH)
    ) u_wr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_req && !wr_full),
        .din      (wr_in),
        .pop      (m_axis_tvalid && m_axis_tready),
        .dout     (wr_head),
        .full     (wr_full),
        .empty    (wr_empty),
        .used_nxt (wr_used_nxt)
    );

    assign wr_word       = fx3_word_t'(wr_head);
    assign m_axis_tvalid = !wr_empty;
    assign m_axis_tdata  = wr_word.data;
    assign m_axis_tlast  = wr_word.last;

    fx3_resp_fifo #(
        .W     (FX3_DW),
        .DEPTH (DEPTH)
    ) u_rd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (s_axis_tvalid && s_axis_tready),
        .din      (s_axis_tdata),
        .pop      (rd_req),
        .dout     (rd_head),
        .full     (rd_full),
        .empty    (rd_empty),
        .used_nxt (rd_used_nxt)
    );

    // Host side stays not-ready while reset is held.
    assign s_axis_tready = ready_en && !rd_full;

    assign flagc = 1'b0;
    assign flagd = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en    <= 1'b0;
            flaga       <= 1'b0;
            flagb       <= 1'b0;
            usb_dout_oe <= 1'b0;
            usb_dout    <= '0;
            pipe_v      <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
            zlp_count   <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            ready_en    <= 1'b1;
            flaga       <= (UW'(DEPTH) - wr_used_nxt) > UW'(WATERMARK);
            // Below the watermark, keep flagb up while the host is idle
            // so a short tail can still be drained.
            flagb       <= (rd_used_nxt > UW'(WATERMARK)) ||
                           ((rd_used_nxt != '0) && !s_axis_tvalid);
            usb_dout_oe <= !slcs_n && !sloe_n;

            pipe_v    <= {pipe_v[RD_LATENCY-2:0], rd_pop_ok};
            pipe_d[0] <= rd_head;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_d[i] <= pipe_d[i-1];
            end
            if (pipe_v[RD_LATENCY-1]) begin
                usb_dout <= pipe_d[RD_LATENCY-1];
            end

            if (zlp_req) begin
                zlp_count <= zlp_count + 16'd1;
            end
            if (wr_req && wr_full) begin
                overflow <= 1'b1;
            end
            if (rd_req && rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fx3_slave_fifo_responder.sv
// Self-checking bench for fx3_slave_fifo_responder.
// Directed table vectors plus hand sequences for bursts and reset.
module tb_fx3_slave_fifo_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  usb_addr;
    logic [31:0] usb_din;
    logic [31:0] usb_dout;
    logic        usb_dout_oe;
    logic        slcs_n, slwr_n, slrd_n, sloe_n, pktend_n;
    logic        flaga, flagb, flagc, flagd;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready;
    logic [15:0] zlp_count;
    logic        overflow, underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fx3_slave_fifo_responder #(
        .DEPTH      (512),
        .WATERMARK  (4),
        .RD_LATENCY (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .usb_addr      (usb_addr),
        .usb_din       (usb_din),
        .usb_dout      (usb_dout),
        .usb_dout_oe   (usb_dout_oe),
        .slcs_n        (slcs_n),
        .slwr_n        (slwr_n),
        .slrd_n        (slrd_n),
        .sloe_n        (sloe_n),
        .pktend_n      (pktend_n),
        .flaga         (flaga),
        .flagb         (flagb),
        .flagc         (flagc),
        .flagd         (flagd),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .zlp_count     (zlp_count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    typedef struct {
        logic       cs_n, wr_n, rd_n, oe_n, pk_n;
        logic [1:0] addr;
        logic       e_oe, e_mv, e_ovf, e_unf;
        logic [15:0] e_zlp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        slcs_n   = 1'b1;
        slwr_n   = 1'b1;
        slrd_n   = 1'b1;
        sloe_n   = 1'b1;
        pktend_n = 1'b1;
        usb_addr = 2'b00;
    endtask

    initial begin
        // cs_n wr_n rd_n oe_n pk_n addr | oe mv ovf unf zlp
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10,
                    1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11,
                    1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10,
                    1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

        rst_n         = 1'b0;
        usb_din       = '0;
        m_axis_tready = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        idle();

        // Reset state
        tick();
        tick();
        chk("rst_flaga", 32'(flaga), 32'd0);
        chk("rst_flagb", 32'(flagb), 32'd0);
        chk("rst_oe", 32'(usb_dout_oe), 32'd0);
        chk("rst_dout", usb_dout, 32'd0);
        chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_sready", 32'(s_axis_tready), 32'd0);
        chk("rst_zlp", 32'(zlp_count), 32'd0);
        chk("rst_err", {30'd0, overflow, underflow}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_flaga", 32'(flaga), 32'd1);
        chk("rel_flagb", 32'(flagb), 32'd0);
        chk("rel_sready", 32'(s_axis_tready), 32'd1);

        // Table: ignored addresses, oe, chip select, zlp
        for (int i = 0; i < 6; i++) begin
            slcs_n   = vecs[i].cs_n;
            slwr_n   = vecs[i].wr_n;
            slrd_n   = vecs[i].rd_n;
            sloe_n   = vecs[i].oe_n;
            pktend_n = vecs[i].pk_n;
            usb_addr = vecs[i].addr;
            usb_din  = 32'hDEAD_0000 + 32'(i);
            tick();
            chk($sformatf("v%0d_oe", i), 32'(usb_dout_oe), 32'(vecs[i].e_oe));
            chk($sformatf("v%0d_mv", i), 32'(m_axis_tvalid), 32'(vecs[i].e_mv));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(vecs[i].e_unf));
            chk($sformatf("v%0d_zlp", i), 32'(zlp_count), 32'(vecs[i].e_zlp));
            chk($sformatf("v%0d_flagb", i), 32'(flagb), 32'd0);
            chk($sformatf("v%0d_flagcd", i), {30'd0, flagc, flagd}, 32'd0);
        end
        idle();

        // Three-word packet, pktend on the last word
        for (int i = 0; i < 3; i++) begin
            slcs_n   = 1'b0;
            usb_addr = 2'b00;
            slwr_n   = 1'b0;
            pktend_n = (i == 2) ? 1'b0 : 1'b1;
            usb_din  = 32'hA + 32'(i);
            tick();
        end
        idle();
        tick();
        chk("pkt_zlp", 32'(zlp_count), 32'd1);
        chk("pkt_v0", 32'(m_axis_tvalid), 32'd1);
        chk("pkt_d0", m_axis_tdata, 32'hA);
        chk("pkt_l0", 32'(m_axis_tlast), 32'd0);
        tick();
        chk("pkt_hold", m_axis_tdata, 32'hA);
        m_axis_tready = 1'b1;
        tick();
        chk("pkt_d1", m_axis_tdata, 32'hB);
        chk("pkt_l1", 32'(m_axis_tlast), 32'd0);
        tick();
        chk("pkt_d2", m_axis_tdata, 32'hC);
        chk("pkt_l2", 32'(m_axis_tlast), 32'd1);
        tick();
        chk("pkt_empty", 32'(m_axis_tvalid), 32'd0);
        m_axis_tready = 1'b0;

        // Fill the write buffer to the flag point, then to full, then over
        for (int i = 0; i < 508; i++) begin
            slcs_n   = 1'b0;
            usb_addr = 2'b00;
            slwr_n   = 1'b0;
            usb_din  = 32'(i);
            tick();
            chk($sformatf("fill_flaga_%0d", i), 32'(flaga),
                (i < 507) ? 32'd1 : 32'd0);
        end
        for (int i = 508; i < 512; i++) begin
            usb_din = 32'(i);
            tick();
        end
        chk("full_ovf0", 32'(overflow), 32'd0);
        chk("full_flaga", 32'(flaga), 32'd0);
        usb_din = 32'd999;
        tick();
        chk("full_ovf1", 32'(overflow), 32'd1);
        idle();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 512; i++) begin
            chk($sformatf("drain_v_%0d", i), 32'(m_axis_tvalid), 32'd1);
            chk($sformatf("drain_d_%0d", i), m_axis_tdata, 32'(i));
            tick();
        end
        chk("drain_end", 32'(m_axis_tvalid), 32'd0);
        chk("drain_flaga", 32'(flaga), 32'd1);
        m_axis_tready = 1'b0;

        // Host loads 16 words, master reads 17
        for (int i = 0; i < 16; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h100 + 32'(i);
            chk($sformatf("host_rdy_%0d", i), 32'(s_axis_tready), 32'd1);
            tick();
        end
        s_axis_tvalid = 1'b0;
        chk("rd_flagb_up", 32'(flagb), 32'd1);
        slcs_n   = 1'b0;
        usb_addr = 2'b01;
        sloe_n   = 1'b0;
        chk("rd_oe_pre", 32'(usb_dout_oe), 32'd0);
        tick();
        chk("rd_oe_post", 32'(usb_dout_oe), 32'd1);
        for (int t = 0; t < 19; t++) begin
            slrd_n = (t < 17) ? 1'b0 : 1'b1;
            tick();
            if (t >= 2) begin
                chk($sformatf("rd_dout_%0d", t), usb_dout,
                    32'h100 + 32'((t - 2 > 15) ? 15 : t - 2));
            end
            if (t <= 15) begin
                chk($sformatf("rd_flagb_%0d", t), 32'(flagb),
                    (t < 15) ? 32'd1 : 32'd0);
            end
            chk($sformatf("rd_unf_%0d", t), 32'(underflow),
                (t >= 16) ? 32'd1 : 32'd0);
        end
        chk("rd_ovf_clean", 32'(overflow), 32'd1);

        // Reset in the middle of a read burst
        slrd_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h200 + 32'(i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        slrd_n = 1'b0;
        tick();
        tick();
        chk("mid_dout_old", usb_dout, 32'h10F);
        chk("mid_oe", 32'(usb_dout_oe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_oe", 32'(usb_dout_oe), 32'd0);
        chk("arst_dout", usb_dout, 32'd0);
        chk("arst_flagb", 32'(flagb), 32'd0);
        chk("arst_unf", 32'(underflow), 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_flagb_%0d", i), 32'(flagb), 32'd0);
            chk($sformatf("post_dout_%0d", i), usb_dout, 32'd0);
            chk($sformatf("post_mv_%0d", i), 32'(m_axis_tvalid), 32'd0);
        end
        chk("post_flaga", 32'(flaga), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
